// File: rtl/mm_tile_sequencer_if.sv
// mm_tile_sequencer_if: job and A/B instruction handshake bundle for the tile sequencer
interface mm_tile_sequencer_if #(
  parameter int N = 4,
  parameter int MEMORY_ADDRESS_BITS = 64,
  parameter int MAX_MATRIX_LENGTH = 4096,
  parameter int COUNTER_BITS = $clog2(MAX_MATRIX_LENGTH + 1),
  parameter int REPEATS_COUNTER_BITS = $clog2(MAX_MATRIX_LENGTH / N + 1)
);
  logic                            job_valid;
  logic                            job_ready;
  logic [MEMORY_ADDRESS_BITS-1:0]  a_base_address;
  logic [MEMORY_ADDRESS_BITS-1:0]  b_base_address;
  logic [COUNTER_BITS-1:0]         k_length;
  logic [REPEATS_COUNTER_BITS-1:0] row_tiles;
  logic [REPEATS_COUNTER_BITS-1:0] col_tiles;
  logic                            a_instruction_valid;
  logic                            a_instruction_ready;
  logic [MEMORY_ADDRESS_BITS-1:0]  a_address;
  logic [COUNTER_BITS-1:0]         a_length;
  logic [REPEATS_COUNTER_BITS-1:0] a_repeats;
  logic                            b_instruction_valid;
  logic                            b_instruction_ready;
  logic [MEMORY_ADDRESS_BITS-1:0]  b_address;
  logic [COUNTER_BITS-1:0]         b_length;
  logic [REPEATS_COUNTER_BITS-1:0] b_repeats;
  logic                            busy;
  logic                            done;
  modport master (
    input  job_valid, a_base_address, b_base_address, k_length, row_tiles, col_tiles,
           a_instruction_ready, b_instruction_ready,
    output job_ready, a_instruction_valid, a_address, a_length, a_repeats,
           b_instruction_valid, b_address, b_length, b_repeats, busy, done
  );
  modport slave (
    output job_valid, a_base_address, b_base_address, k_length, row_tiles, col_tiles,
           a_instruction_ready, b_instruction_ready,
    input  job_ready, a_instruction_valid, a_address, a_length, a_repeats,
           b_instruction_valid, b_address, b_length, b_repeats, busy, done
  );
endinterface

// File: rtl/mm_tile_sequencer.sv
// mm_tile_sequencer: walks an A-row x B-column tile grid, issuing one A then col_tiles B instructions per row.
// Define MM_SEQ_STALL_COUNT_EN to add the saturating 32-bit stall_cycles counter output.
module mm_tile_sequencer #(
  parameter int N = 4,
  parameter int MEMORY_ADDRESS_BITS = 64,
  parameter int MAX_MATRIX_LENGTH = 4096,
  parameter int COUNTER_BITS = $clog2(MAX_MATRIX_LENGTH + 1),
  parameter int REPEATS_COUNTER_BITS = $clog2(MAX_MATRIX_LENGTH / N + 1)
) (
  input  logic clk,
  input  logic reset_n,
  mm_tile_sequencer_if.master bus
`ifdef MM_SEQ_STALL_COUNT_EN
  , output logic [31:0] stall_cycles
`endif
);
  localparam int AW = MEMORY_ADDRESS_BITS;
  localparam int CB = COUNTER_BITS;
  localparam int RB = REPEATS_COUNTER_BITS;
  localparam logic [RB-1:0] R_ONE = RB'(1);
  typedef enum logic [1:0] {IDLE, ISSUE_A, ISSUE_B, FINISH} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [AW-1:0] b_base_q, b_base_d, stride_q, stride_d;
  logic [CB-1:0] k_q, k_d;
  logic [RB-1:0] rows_q, rows_d, cols_q, cols_d, row_q, row_d, col_q, col_d;
  logic accept, a_fire, b_fire, last_col, last_row, empty_job;
  always_comb begin
    accept    = bus.job_valid && state_q == IDLE;
    a_fire    = state_q == ISSUE_A && bus.a_instruction_ready;
    b_fire    = state_q == ISSUE_B && bus.b_instruction_ready;
    last_col  = col_q == cols_q - R_ONE;
    last_row  = row_q == rows_q - R_ONE;
    empty_job = bus.k_length == '0 || bus.row_tiles == '0 || bus.col_tiles == '0;
  end
  always_comb begin
    state_d  = state_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    b_base_d = b_base_q;
    stride_d = stride_q;
    k_d      = k_q;
    rows_d   = rows_q;
    cols_d   = cols_q;
    row_d    = row_q;
    col_d    = col_q;
    case (state_q)
      IDLE: if (accept) begin
        k_d      = bus.k_length;
        rows_d   = bus.row_tiles;
        cols_d   = bus.col_tiles;
        a_addr_d = bus.a_base_address;
        b_base_d = bus.b_base_address;
        b_addr_d = bus.b_base_address;
        // the only multiply: stride is fixed for the whole job, then accumulated
        stride_d = AW'(N) * AW'(bus.k_length);
        row_d    = '0;
        col_d    = '0;
        state_d  = empty_job ? FINISH : ISSUE_A;
      end
      ISSUE_A: if (a_fire) begin
        col_d    = '0;
        b_addr_d = b_base_q;
        state_d  = ISSUE_B;
      end
      ISSUE_B: if (b_fire) begin
        if (!last_col) begin
          col_d    = col_q + R_ONE;
          b_addr_d = b_addr_q + stride_q;
        end else if (!last_row) begin
          row_d    = row_q + R_ONE;
          a_addr_d = a_addr_q + stride_q;
          state_d  = ISSUE_A;
        end else begin
          state_d  = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs decode straight from the state register so reset clears them immediately
  always_comb begin
    bus.job_ready           = state_q == IDLE;
    bus.busy                = state_q != IDLE;
    bus.done                = state_q == FINISH;
    bus.a_instruction_valid = state_q == ISSUE_A;
    bus.a_address           = bus.a_instruction_valid ? a_addr_q : '0;
    bus.a_length            = bus.a_instruction_valid ? k_q : '0;
    bus.a_repeats           = bus.a_instruction_valid ? cols_q : '0;
    bus.b_instruction_valid = state_q == ISSUE_B;
    bus.b_address           = bus.b_instruction_valid ? b_addr_q : '0;
    bus.b_length            = bus.b_instruction_valid ? k_q : '0;
    bus.b_repeats           = bus.b_instruction_valid ? R_ONE : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_addr_q <= '0;
      b_addr_q <= '0;
      b_base_q <= '0;
      stride_q <= '0;
      k_q      <= '0;
      rows_q   <= '0;
      cols_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      b_base_q <= b_base_d;
      stride_q <= stride_d;
      k_q      <= k_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end
`ifdef MM_SEQ_STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;
  logic stall;
  always_comb begin
    stall   = (bus.a_instruction_valid && !bus.a_instruction_ready) ||
              (bus.b_instruction_valid && !bus.b_instruction_ready);
    stall_d = accept ? '0 : (stall && ~&stall_q) ? stall_q + 32'd1 : stall_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_mm_tile_sequencer.sv
// tb_mm_tile_sequencer: directed vectors against hand-computed instruction streams.
module tb_mm_tile_sequencer;
  localparam int AW = 64;
  localparam int CB = 13;
  localparam int RB = 11;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  mm_tile_sequencer_if #(.N(4), .MEMORY_ADDRESS_BITS(AW)) bus ();
`ifdef MM_SEQ_STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif
  mm_tile_sequencer #(.N(4), .MEMORY_ADDRESS_BITS(AW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.master)
`ifdef MM_SEQ_STALL_COUNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  typedef struct {
    logic        b;
    logic [63:0] addr;
    logic [63:0] len;
    logic [63:0] rep;
  } ins_t;
  ins_t log_q[$];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic exp_ins(string t, int i, logic b, logic [63:0] a, logic [63:0] l, logic [63:0] r);
    if (i < log_q.size()) begin
      chk({t, "_kind"}, 64'(log_q[i].b), 64'(b));
      chk({t, "_addr"}, log_q[i].addr, a);
      chk({t, "_len"}, log_q[i].len, l);
      chk({t, "_rep"}, log_q[i].rep, r);
    end else chk({t, "_missing"}, 64'(log_q.size()), 64'(i + 1));
  endtask
  task automatic start_job(logic [63:0] a, logic [63:0] b, logic [CB-1:0] k, logic [RB-1:0] r, logic [RB-1:0] c);
    bus.a_base_address = a;
    bus.b_base_address = b;
    bus.k_length = k;
    bus.row_tiles = r;
    bus.col_tiles = c;
    bus.job_valid = 1'b1;
    chk("job_ready_at_accept", 64'(bus.job_ready), 64'd1);
    @(posedge clk);
    #1 bus.job_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic wait_done(string t);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    chk({t, "_done_seen"}, 64'(seen), 64'd1);
  endtask
  task automatic wait_bvalid(string t);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus.b_instruction_valid) seen = 1'b1;
      else @(negedge clk);
    end
    chk({t, "_bvalid_seen"}, 64'(seen), 64'd1);
  endtask
  always @(posedge clk) begin
    if (bus.a_instruction_valid && bus.a_instruction_ready)
      log_q.push_back('{1'b0, 64'(bus.a_address), 64'(bus.a_length), 64'(bus.a_repeats)});
    if (bus.b_instruction_valid && bus.b_instruction_ready)
      log_q.push_back('{1'b1, 64'(bus.b_address), 64'(bus.b_length), 64'(bus.b_repeats)});
    if (bus.done) done_cnt++;
  end
  always @(negedge clk)
    if (bus.a_instruction_valid && bus.b_instruction_valid) chk("mutex_valid", 64'd1, 64'd0);
  initial begin
    bus.job_valid = 1'b0;
    bus.a_base_address = '0;
    bus.b_base_address = '0;
    bus.k_length = '0;
    bus.row_tiles = '0;
    bus.col_tiles = '0;
    bus.a_instruction_ready = 1'b1;
    bus.b_instruction_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_job_ready", 64'(bus.job_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_a_valid", 64'(bus.a_instruction_valid), 64'd0);
    chk("rst_b_valid", 64'(bus.b_instruction_valid), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_a_addr", 64'(bus.a_address), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    // basic 2x3 grid, readies high
    log_q.delete();
    start_job(64'h1000, 64'h8000, 13'd8, 11'd2, 11'd3);
    chk("t1_lat_a_valid", 64'(bus.a_instruction_valid), 64'd1);
    chk("t1_lat_a_addr", 64'(bus.a_address), 64'h1000);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    wait_done("t1");
    chk("t1_count", 64'(log_q.size()), 64'd8);
    exp_ins("t1_a0", 0, 1'b0, 64'h1000, 64'd8, 64'd3);
    exp_ins("t1_b0", 1, 1'b1, 64'h8000, 64'd8, 64'd1);
    exp_ins("t1_b1", 2, 1'b1, 64'h8020, 64'd8, 64'd1);
    exp_ins("t1_b2", 3, 1'b1, 64'h8040, 64'd8, 64'd1);
    exp_ins("t1_a1", 4, 1'b0, 64'h1020, 64'd8, 64'd3);
    exp_ins("t1_b3", 5, 1'b1, 64'h8000, 64'd8, 64'd1);
    exp_ins("t1_b4", 6, 1'b1, 64'h8020, 64'd8, 64'd1);
    exp_ins("t1_b5", 7, 1'b1, 64'h8040, 64'd8, 64'd1);
    @(negedge clk);
    chk("t1_done_pulse", 64'(bus.done), 64'd0);
    chk("t1_ready_back", 64'(bus.job_ready), 64'd1);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    // B stalled for five cycles
    log_q.delete();
    bus.b_instruction_ready = 1'b0;
    start_job(64'h200, 64'h400, 13'd4, 11'd1, 11'd3);
    wait_bvalid("t2");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_hold_addr%0d", i), 64'(bus.b_address), 64'h400);
      chk($sformatf("t2_hold_valid%0d", i), 64'(bus.b_instruction_valid), 64'd1);
      @(negedge clk);
    end
    bus.b_instruction_ready = 1'b1;
    wait_done("t2");
    chk("t2_count", 64'(log_q.size()), 64'd4);
    exp_ins("t2_a0", 0, 1'b0, 64'h200, 64'd4, 64'd3);
    exp_ins("t2_b0", 1, 1'b1, 64'h400, 64'd4, 64'd1);
    exp_ins("t2_b1", 2, 1'b1, 64'h410, 64'd4, 64'd1);
    exp_ins("t2_b2", 3, 1'b1, 64'h420, 64'd4, 64'd1);
`ifdef MM_SEQ_STALL_COUNT_EN
    chk("t2_stall_cycles", 64'(stall_cycles), 64'd5);
`endif
    @(negedge clk);
    // empty job then a job accepted in the first IDLE cycle
    log_q.delete();
    start_job(64'h10, 64'h20, 13'd8, 11'd2, 11'd0);
    chk("t3_done", 64'(bus.done), 64'd1);
    chk("t3_a_valid", 64'(bus.a_instruction_valid), 64'd0);
    chk("t3_b_valid", 64'(bus.b_instruction_valid), 64'd0);
    @(negedge clk);
    chk("t3_done_low", 64'(bus.done), 64'd0);
    chk("t3_ready", 64'(bus.job_ready), 64'd1);
    chk("t3_count", 64'(log_q.size()), 64'd0);
    start_job(64'h40, 64'h80, 13'd2, 11'd1, 11'd1);
    chk("t3b_a_valid", 64'(bus.a_instruction_valid), 64'd1);
    wait_done("t3b");
    chk("t3b_count", 64'(log_q.size()), 64'd2);
    exp_ins("t3b_a0", 0, 1'b0, 64'h40, 64'd2, 64'd1);
    exp_ins("t3b_b0", 1, 1'b1, 64'h80, 64'd2, 64'd1);
    @(negedge clk);
    // address wrap
    log_q.delete();
    start_job(64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 13'd8, 11'd2, 11'd1);
    wait_done("t4");
    chk("t4_count", 64'(log_q.size()), 64'd4);
    exp_ins("t4_a0", 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 64'd1);
    exp_ins("t4_b0", 1, 1'b1, 64'h0, 64'd8, 64'd1);
    exp_ins("t4_a1", 2, 1'b0, 64'h10, 64'd8, 64'd1);
    exp_ins("t4_b1", 3, 1'b1, 64'h0, 64'd8, 64'd1);
    @(negedge clk);
    // reset during ISSUE_B
    log_q.delete();
    start_job(64'h3000, 64'h5000, 13'd4, 11'd2, 11'd2);
    wait_bvalid("t5");
    reset_n = 1'b0;
    #1;
    chk("t5_a_valid", 64'(bus.a_instruction_valid), 64'd0);
    chk("t5_b_valid", 64'(bus.b_instruction_valid), 64'd0);
    chk("t5_b_addr", 64'(bus.b_address), 64'd0);
    chk("t5_b_len", 64'(bus.b_length), 64'd0);
    chk("t5_b_rep", 64'(bus.b_repeats), 64'd0);
    chk("t5_done", 64'(bus.done), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_ready", 64'(bus.job_ready), 64'd1);
`ifdef MM_SEQ_STALL_COUNT_EN
    chk("t5_stall_rst", 64'(stall_cycles), 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    chk("t5_pre_count", 64'(log_q.size()), 64'd1);
    log_q.delete();
    repeat (10) @(negedge clk);
    chk("t5_post_count", 64'(log_q.size()), 64'd0);
    chk("t5_post_busy", 64'(bus.busy), 64'd0);
    chk("t5_done_cnt", 64'(done_cnt), 64'd5);
    start_job(64'h100, 64'h200, 13'd1, 11'd1, 11'd1);
    wait_done("t6");
    chk("t6_count", 64'(log_q.size()), 64'd2);
    exp_ins("t6_a0", 0, 1'b0, 64'h100, 64'd1, 64'd1);
    exp_ins("t6_b0", 1, 1'b1, 64'h200, 64'd1, 64'd1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mm_tile_sequencer.md
MM_TILE_SEQUENCER -- requirements
Module: mm_tile_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: processor width; tile edge.
REQ-002 SHALL have parameter MEMORY_ADDRESS_BITS, default 64: address width.
REQ-003 SHALL have parameter MAX_MATRIX_LENGTH, default 4096: largest K.
REQ-004 SHALL have parameter COUNTER_BITS, default $clog2(MAX_MATRIX_LENGTH+1): width of the length field.
REQ-005 SHALL have parameter REPEATS_COUNTER_BITS, default $clog2(MAX_MATRIX_LENGTH/N+1): width of the tile and repeat fields.
REQ-006 SHALL have port clk, input, 1: the single clock; all state rises on posedge.
REQ-007 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have ports job_valid (input, 1) and job_ready (output, 1): job handshake.
REQ-009 SHALL have ports a_base_address and b_base_address, input, MEMORY_ADDRESS_BITS: start addresses of A and B.
REQ-010 SHALL have ports k_length (input, COUNTER_BITS), row_tiles and col_tiles (input, REPEATS_COUNTER_BITS): job dimensions.
REQ-011 SHALL have ports a_instruction_valid (output, 1) and a_instruction_ready (input, 1): A-buffer instruction handshake.
REQ-012 SHALL have ports a_address (output, MEMORY_ADDRESS_BITS), a_length (output, COUNTER_BITS) and a_repeats (output, REPEATS_COUNTER_BITS): A instruction.
REQ-013 SHALL have B ports b_instruction_valid, b_instruction_ready, b_address, b_length and b_repeats, with the same widths as the A set.
REQ-014 SHALL have ports busy (output, 1), high when not IDLE, and done (output, 1), a one-cycle completion pulse.

Function
REQ-015 SHALL sample all job inputs into registers on the cycle where job_valid && job_ready; job_ready = (state==IDLE).
REQ-016 SHALL implement FSM IDLE -> ISSUE_A -> ISSUE_B -> (ISSUE_A | FINISH) -> IDLE.
REQ-017 SHALL, in ISSUE_A, hold a_instruction_valid=1 with a_address=a_base+row*N*k_length, a_length=k_length, a_repeats=col_tiles; on handshake go to ISSUE_B with col=0.
REQ-018 SHALL, in ISSUE_B, hold b_instruction_valid=1 with b_address=b_base+col*N*k_length, b_length=k_length, b_repeats=1; each handshake increments col.
REQ-019 SHALL, on the B handshake with col==col_tiles-1, increment row and go to ISSUE_A, or go to FINISH when row==row_tiles-1.
REQ-020 SHALL, in FINISH, pulse done for exactly one cycle, then return to IDLE.
REQ-021 SHALL compute addresses with running accumulators that add the stride N*k_length, with no per-cycle multiplier; the stride is computed once at job accept.
REQ-022 SHALL wrap address arithmetic modulo 2^MEMORY_ADDRESS_BITS.
REQ-023 SHALL keep instruction outputs stable while valid && !ready; valid SHALL never drop without a handshake.
REQ-024 SHALL drive instruction outputs to 0 whenever the matching valid is low.
REQ-025 SHALL never assert a_instruction_valid and b_instruction_valid in the same cycle.
REQ-026 SHALL treat a job with k_length==0, row_tiles==0 or col_tiles==0 as empty: no instructions, go straight to FINISH, done pulse one cycle after accept.
REQ-027 SHALL allow a new job to be accepted in the first IDLE cycle after FINISH.
REQ-028 SHALL have a minimum latency from accept to first A valid of 1 cycle.

Reset
REQ-029 SHALL, while reset_n=0, force state IDLE, all counters and accumulators to 0, and all valid, done and data outputs to 0, with job_ready=1.
REQ-030 SHALL abort any in-flight job on reset assertion mid-operation, with no further instructions after reset is released.

Configuration
REQ-031 SHALL add, when MM_SEQ_STALL_COUNT_EN is defined, output stall_cycles (32 bits) that counts cycles with (a_instruction_valid && !a_instruction_ready) || (b_instruction_valid && !b_instruction_ready).
REQ-032 SHALL clear stall_cycles on job accept and on reset, and saturate it at all-ones.
REQ-033 SHALL, when MM_SEQ_STALL_COUNT_EN is undefined, omit the stall_cycles port and counter with all other behaviour identical.

Verification
REQ-034 SHALL cover: N=4, a_base=0x1000, b_base=0x8000, k=8, row_tiles=2, col_tiles=3, readies tied high -> A(0x1000,8,3), B 0x8000/0x8020/0x8040, A(0x1020,8,3), B 0x8000/0x8020/0x8040, done pulse.
REQ-035 SHALL cover: b_instruction_ready low for 5 cycles mid-job -> b_address held stable and no instruction duplicated or skipped; stall_cycles=5 when MM_SEQ_STALL_COUNT_EN is defined.
REQ-036 SHALL cover: a job with col_tiles=0 -> no valids, done one cycle after accept, job_ready back to 1.
REQ-037 SHALL cover: a_base=0xFFFF_FFFF_FFFF_FFF0, k=8, row_tiles=2 -> second a_address=0x0000_0000_0000_0010.
REQ-038 SHALL cover: reset_n pulsed low during ISSUE_B -> all outputs 0 immediately, job_ready=1, no instructions afterward until a new job.
